// File: rtl/coax_pkg.sv
// Shared constants and types for the coax receive buffer.
// Optional feature macro: COAX_RX_BUFFER_FIRST_WORD_MARK_EN (adds first-word marker bit).
package coax_pkg;

    localparam int unsigned WORD_W = 10;

`ifdef COAX_RX_BUFFER_FIRST_WORD_MARK_EN
    localparam int unsigned DATA_W = WORD_W + 1;
`else
    localparam int unsigned DATA_W = WORD_W;
`endif

    localparam logic [WORD_W-1:0] LOSS_OF_MID_BIT_TRANSITION_ERROR = 10'd1;
    localparam logic [WORD_W-1:0] PARITY_ERROR                     = 10'd2;
    localparam logic [WORD_W-1:0] OVERFLOW_ERROR                   = 10'd4;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RECEIVING = 2'd1,
        ST_ERROR     = 2'd2
    } buf_state_t;

endpackage

// File: rtl/coax_fifo.sv
// Generic synchronous first-word-fall-through FIFO.
module coax_fifo #(
    parameter int unsigned WIDTH      = 10,
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_wr_en,
    input  logic [WIDTH-1:0]      i_wr_data,
    input  logic                  i_rd_en,
    output logic [WIDTH-1:0]      o_rd_data,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [ADDR_WIDTH:0]   o_count
);

    logic [WIDTH-1:0]      r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_full;
    logic                  r_empty;
    logic                  w_do_rd;
    logic                  w_do_wr;
    logic [ADDR_WIDTH:0]   w_count_next;

    // Read only when data is present; write when space exists or a read frees a slot.
    always_comb begin
        w_do_rd      = i_rd_en & ~r_empty;
        w_do_wr      = i_wr_en & (~r_full | w_do_rd);
        w_count_next = r_count;
        if (w_do_wr && !w_do_rd) begin
            w_count_next = r_count + (ADDR_WIDTH+1)'(1);
        end else if (w_do_rd && !w_do_wr) begin
            w_count_next = r_count - (ADDR_WIDTH+1)'(1);
        end
    end

    // Pointer, occupancy and flag registers; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_do_wr) r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
            if (w_do_rd) r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
            r_count <= w_count_next;
            r_full  <= (w_count_next == (ADDR_WIDTH+1)'(DEPTH));
            r_empty <= (w_count_next == '0);
        end
    end

    // Storage array; contents need no reset.
    always_ff @(posedge clk) begin
        if (w_do_wr) r_mem[r_wr_ptr] <= i_wr_data;
    end

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_full    = r_full;
    assign o_empty   = r_empty;
    assign o_count   = r_count;

endmodule

// File: rtl/coax_rx_buffer.sv
// Coax receive buffer: message tracking, error capture and write gating in front of a FWFT FIFO.
// Optional feature macro: COAX_RX_BUFFER_FIRST_WORD_MARK_EN (bit 10 of data flags a message's first word).
module coax_rx_buffer
    import coax_pkg::*;
#(
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_data_valid,
    input  logic [WORD_W-1:0]     rx_data,
    input  logic                  rx_active,
    input  logic                  rx_error,
    input  logic                  read_strobe,
    input  logic                  clear,
    output logic [DATA_W-1:0]     data,
    output logic                  empty,
    output logic                  full,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  message_done,
    output logic                  error,
    output logic [WORD_W-1:0]     error_code
);

    buf_state_t          r_state;
    buf_state_t          w_state_next;
    logic                r_prev_active;
    logic                r_message_done;
    logic                w_message_done_next;
    logic                r_error;
    logic [WORD_W-1:0]   r_error_code;
    logic [WORD_W-1:0]   w_error_code_next;
    logic                w_wr_en;
    logic                w_rd_en;
    logic [DATA_W-1:0]   w_wr_data;
    logic                w_full;
    logic                w_empty;

    // Next-state, error capture and write gating.
    always_comb begin
        w_state_next        = r_state;
        w_error_code_next   = r_error_code;
        w_message_done_next = 1'b0;
        w_wr_en             = 1'b0;
        w_rd_en             = read_strobe & ~w_empty;
        case (r_state)
            ST_IDLE: begin
                if (rx_active && !r_prev_active) w_state_next = ST_RECEIVING;
            end
            ST_RECEIVING: begin
                if (rx_error) begin
                    w_state_next      = ST_ERROR;
                    w_error_code_next = rx_data;
                end else if (!rx_active) begin
                    w_state_next        = ST_IDLE;
                    w_message_done_next = 1'b1;
                end else if (rx_data_valid) begin
                    if (!w_full || w_rd_en) begin
                        w_wr_en = 1'b1;
                    end else begin
                        w_state_next      = ST_ERROR;
                        w_error_code_next = OVERFLOW_ERROR;
                    end
                end
            end
            ST_ERROR: begin
                if (clear) begin
                    w_state_next      = ST_IDLE;
                    w_error_code_next = '0;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State, edge-detect and status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_prev_active  <= 1'b1;
            r_message_done <= 1'b0;
            r_error        <= 1'b0;
            r_error_code   <= '0;
        end else begin
            r_state        <= w_state_next;
            r_prev_active  <= rx_active;
            r_message_done <= w_message_done_next;
            r_error        <= (w_state_next == ST_ERROR);
            r_error_code   <= w_error_code_next;
        end
    end

`ifdef COAX_RX_BUFFER_FIRST_WORD_MARK_EN
    logic r_first;
    logic w_first_next;

    // Arm the marker on message start; consume it on the first stored word.
    always_comb begin
        w_first_next = r_first;
        if (r_state == ST_IDLE && w_state_next == ST_RECEIVING) begin
            w_first_next = 1'b1;
        end else if (w_wr_en) begin
            w_first_next = 1'b0;
        end
    end

    // First-word marker register.
    always_ff @(posedge clk) begin
        if (reset) r_first <= 1'b0;
        else       r_first <= w_first_next;
    end

    assign w_wr_data = {r_first, rx_data};
`else
    assign w_wr_data = rx_data;
`endif

    coax_fifo #(
        .WIDTH      (DATA_W),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_wr_en   (w_wr_en),
        .i_wr_data (w_wr_data),
        .i_rd_en   (w_rd_en),
        .o_rd_data (data),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_count   (count)
    );

    assign empty        = w_empty;
    assign full         = w_full;
    assign message_done = r_message_done;
    assign error        = r_error;
    assign error_code   = r_error_code;

endmodule

// File: tb/tb_coax_rx_buffer.sv
// Directed self-checking bench for coax_rx_buffer (DEPTH=4) with a scoreboard queue.
module tb_coax_rx_buffer;
    import coax_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              rx_data_valid;
    logic [WORD_W-1:0] rx_data;
    logic              rx_active;
    logic              rx_error;
    logic              read_strobe;
    logic              clear;
    logic [DATA_W-1:0] data;
    logic              empty;
    logic              full;
    logic [AW:0]       count;
    logic              message_done;
    logic              error;
    logic [WORD_W-1:0] error_code;

    int n_checks = 0;
    int n_fail   = 0;
    logic [DATA_W-1:0] sb [$];

    coax_rx_buffer #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clk           (clk),
        .reset         (reset),
        .rx_data_valid (rx_data_valid),
        .rx_data       (rx_data),
        .rx_active     (rx_active),
        .rx_error      (rx_error),
        .read_strobe   (read_strobe),
        .clear         (clear),
        .data          (data),
        .empty         (empty),
        .full          (full),
        .count         (count),
        .message_done  (message_done),
        .error         (error),
        .error_code    (error_code)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] mk(input logic [WORD_W-1:0] w, input logic mark);
        logic [DATA_W-1:0] r;
`ifdef COAX_RX_BUFFER_FIRST_WORD_MARK_EN
        r = {mark, w};
`else
        r = w;
        if (mark) r = w;
`endif
        return r;
    endfunction

    // Strobe one word; push expectation if it should be stored.
    task automatic put(input logic [WORD_W-1:0] w, input bit keep, input logic mark);
        rx_data_valid = 1'b1;
        rx_data       = w;
        if (keep) sb.push_back(mk(w, mark));
        tick();
        rx_data_valid = 1'b0;
    endtask

    // Pop one word from the head and compare against the scoreboard.
    task automatic pop(input string tag);
        logic [DATA_W-1:0] e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_underrun"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_data"}, 32'(data), 32'(e));
        end
        read_strobe = 1'b1;
        tick();
        read_strobe = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_count"}, 32'(count), 32'd0);
        chk({tag, "_empty"}, 32'(empty), 32'd1);
        chk({tag, "_full"}, 32'(full), 32'd0);
        chk({tag, "_error"}, 32'(error), 32'd0);
        chk({tag, "_ecode"}, 32'(error_code), 32'd0);
        chk({tag, "_mdone"}, 32'(message_done), 32'd0);
    endtask

    initial begin
        reset = 1'b1; rx_data_valid = 1'b0; rx_data = '0; rx_active = 1'b0;
        rx_error = 1'b0; read_strobe = 1'b0; clear = 1'b0;
        tick(); tick();
        check_reset_state("rst");
        reset = 1'b0;
        tick();

        // Three-word message, then clean end.
        rx_active = 1'b1; tick();
        put(10'h3FF, 1, 1); put(10'h001, 1, 0); put(10'h2AA, 1, 0);
        chk("m1_count", 32'(count), 32'd3);
        rx_active = 1'b0; tick();
        chk("m1_done_pulse", 32'(message_done), 32'd1);
        tick();
        chk("m1_done_clear", 32'(message_done), 32'd0);
        pop("m1_r0"); pop("m1_r1"); pop("m1_r2");
        chk("m1_empty", 32'(empty), 32'd1);
        chk("m1_count0", 32'(count), 32'd0);

        // Receiver error after one word.
        rx_active = 1'b1; tick();
        put(10'h155, 1, 1);
        rx_error = 1'b1; rx_data = 10'h002; tick();
        rx_error = 1'b0; rx_active = 1'b0;
        chk("e_error", 32'(error), 32'd1);
        chk("e_code", 32'(error_code), 32'(PARITY_ERROR));
        chk("e_count", 32'(count), 32'd1);
        rx_active = 1'b1; tick();
        put(10'h0AB, 0, 0);
        chk("e_drop_count", 32'(count), 32'd1);
        clear = 1'b1; tick(); clear = 1'b0;
        chk("e_clr_error", 32'(error), 32'd0);
        chk("e_clr_code", 32'(error_code), 32'd0);
        chk("e_clr_count", 32'(count), 32'd1);
        put(10'h0CD, 0, 0);
        chk("e_noedge_count", 32'(count), 32'd1);
        rx_active = 1'b0; tick();
        rx_active = 1'b1; tick();
        put(10'h0EF, 1, 1);
        chk("e_new_count", 32'(count), 32'd2);
        rx_active = 1'b0; tick();
        pop("e_r0"); pop("e_r1");

        // Overflow with no reads.
        rx_active = 1'b1; tick();
        put(10'h010, 1, 1); put(10'h011, 1, 0); put(10'h012, 1, 0); put(10'h013, 1, 0);
        chk("ov_full_pre", 32'(full), 32'd1);
        put(10'h014, 0, 0);
        chk("ov_error", 32'(error), 32'd1);
        chk("ov_code", 32'(error_code), 32'(OVERFLOW_ERROR));
        chk("ov_count", 32'(count), 32'd4);
        chk("ov_full", 32'(full), 32'd1);
        rx_active = 1'b0; clear = 1'b1; tick(); clear = 1'b0;
        pop("ov_r0"); pop("ov_r1"); pop("ov_r2"); pop("ov_r3");
        chk("ov_empty", 32'(empty), 32'd1);

        // Full with simultaneous read and write: no overflow.
        rx_active = 1'b1; tick();
        put(10'h020, 1, 1); put(10'h021, 1, 0); put(10'h022, 1, 0); put(10'h023, 1, 0);
        chk("rw_head", 32'(data), 32'(sb[0]));
        void'(sb.pop_front());
        read_strobe = 1'b1;
        put(10'h024, 1, 0);
        read_strobe = 1'b0;
        chk("rw_count", 32'(count), 32'd4);
        chk("rw_full", 32'(full), 32'd1);
        chk("rw_error", 32'(error), 32'd0);
        rx_active = 1'b0; tick();
        pop("rw_r0"); pop("rw_r1"); pop("rw_r2"); pop("rw_r3");

        // Read on empty, then read+write on empty.
        read_strobe = 1'b1; tick(); read_strobe = 1'b0;
        chk("ue_count", 32'(count), 32'd0);
        chk("ue_empty", 32'(empty), 32'd1);
        rx_active = 1'b1; tick();
        read_strobe = 1'b1;
        put(10'h3C3, 1, 1);
        read_strobe = 1'b0;
        chk("ue_rw_count", 32'(count), 32'd1);
        chk("ue_rw_empty", 32'(empty), 32'd0);
        chk("ue_rw_data", 32'(data), 32'(sb[0]));
        rx_active = 1'b0; tick();
        pop("ue_r0");

        // Reset mid-message with rx_active held high.
        rx_active = 1'b1; tick();
        put(10'h111, 0, 0);
        reset = 1'b1; tick();
        check_reset_state("mr");
        reset = 1'b0;
        put(10'h112, 0, 0); put(10'h113, 0, 0);
        chk("mr_count", 32'(count), 32'd0);
        chk("mr_empty", 32'(empty), 32'd1);
        rx_active = 1'b0; tick();
        rx_active = 1'b1; tick();
        put(10'h077, 1, 1); put(10'h078, 1, 0);
        chk("mr_new_count", 32'(count), 32'd2);
        rx_active = 1'b0; tick();
        pop("mr_r0"); pop("mr_r1");

        // Back-to-back two-word messages.
        rx_active = 1'b1; tick();
        put(10'h101, 1, 1); put(10'h102, 1, 0);
        rx_active = 1'b0; tick();
        rx_active = 1'b1; tick();
        put(10'h201, 1, 1); put(10'h202, 1, 0);
        rx_active = 1'b0; tick();
        chk("bb_count", 32'(count), 32'd4);
        pop("bb_r0"); pop("bb_r1"); pop("bb_r2"); pop("bb_r3");
        chk("bb_empty", 32'(empty), 32'd1);
        chk("bb_sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
